// File: rtl/fp_divsqrt_seq.sv
// Control sequencer for the iterative FP divide/square-root unit.
// Classifies captured operands, resolves IEEE special cases directly and
// otherwise drives the shared mantissa datapath for ITERS step cycles.
module fp_divsqrt_seq #(
  parameter int EXP_BITS  = 8,
  parameter int FRAC_BITS = 23,
  parameter int ITERS     = FRAC_BITS + 4
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_valid,
  output logic                         o_ready,
  input  logic                         i_op,
  input  logic                         i_a_sign,
  input  logic [EXP_BITS-1:0]          i_a_exp,
  input  logic [FRAC_BITS-1:0]         i_a_frac,
  input  logic                         i_b_sign,
  input  logic [EXP_BITS-1:0]          i_b_exp,
  input  logic [FRAC_BITS-1:0]         i_b_frac,
  input  logic                         i_kill,
  output logic                         o_dp_start,
  output logic                         o_dp_step,
  output logic [$clog2(ITERS+1)-1:0]   o_iter_cnt,
  output logic                         o_a_subnormal,
  output logic                         o_b_subnormal,
  output logic                         o_result_valid,
  input  logic                         i_result_ready,
  output logic                         o_special,
  output logic [1:0]                   o_special_kind,
  output logic                         o_special_sign,
  output logic                         o_flag_nv,
  output logic                         o_flag_dz
);

  localparam int CW = $clog2(ITERS + 1);
  localparam logic [CW-1:0] LAST = CW'(ITERS - 1);

  typedef enum logic [1:0] {IDLE, CHECK, ITER, DONE} state_t;
  typedef enum logic [1:0] {KIND_QNAN = 2'd0, KIND_INF = 2'd1, KIND_ZERO = 2'd2} kind_t;

  typedef struct packed {
    logic nan;
    logic snan;
    logic inf;
    logic zero;
    logic sub;
  } cls_t;

  function automatic cls_t fp_classify_operand(input logic [EXP_BITS-1:0] e,
                                               input logic [FRAC_BITS-1:0] f);
    cls_t c;
    c.nan  = (&e) && (|f);
    c.snan = c.nan && !f[FRAC_BITS-1];
    c.inf  = (&e) && !(|f);
    c.zero = !(|e) && !(|f);
    c.sub  = !(|e) && (|f);
    return c;
  endfunction

  state_t                state_q, state_d;
  logic                  op_q;
  logic                  a_sign_q, b_sign_q;
  logic [EXP_BITS-1:0]   a_exp_q, b_exp_q;
  logic [FRAC_BITS-1:0]  a_frac_q, b_frac_q;
  logic [CW-1:0]         cnt_q;
  logic                  a_sub_q, b_sub_q;
  logic                  res_special_q, res_sign_q, res_nv_q, res_dz_q;
  kind_t                 res_kind_q;

  cls_t                  a_cls, b_cls;
  logic                  spec_hit, spec_sign, spec_nv, spec_dz;
  kind_t                 spec_kind;

  assign a_cls = fp_classify_operand(a_exp_q, a_frac_q);
  assign b_cls = fp_classify_operand(b_exp_q, b_frac_q);

  // Special-case resolution on the captured operands, first matching rule wins
  always_comb begin
    spec_hit  = 1'b0;
    spec_kind = KIND_QNAN;
    spec_sign = 1'b0;
    spec_nv   = 1'b0;
    spec_dz   = 1'b0;
    if (!op_q) begin
      if (a_cls.nan || b_cls.nan) begin
        spec_hit = 1'b1;
        spec_nv  = a_cls.snan || b_cls.snan;
      end else if ((a_cls.inf && b_cls.inf) || (a_cls.zero && b_cls.zero)) begin
        spec_hit = 1'b1;
        spec_nv  = 1'b1;
      end else if (a_cls.inf) begin
        spec_hit  = 1'b1;
        spec_kind = KIND_INF;
        spec_sign = a_sign_q ^ b_sign_q;
      end else if (b_cls.zero) begin
        spec_hit  = 1'b1;
        spec_kind = KIND_INF;
        spec_sign = a_sign_q ^ b_sign_q;
        spec_dz   = 1'b1;
      end else if (a_cls.zero || b_cls.inf) begin
        spec_hit  = 1'b1;
        spec_kind = KIND_ZERO;
        spec_sign = a_sign_q ^ b_sign_q;
      end
    end else begin
      if (a_cls.nan) begin
        spec_hit = 1'b1;
        spec_nv  = a_cls.snan;
      end else if (a_cls.zero) begin
        spec_hit  = 1'b1;
        spec_kind = KIND_ZERO;
        spec_sign = a_sign_q;
      end else if (a_sign_q) begin
        spec_hit = 1'b1;
        spec_nv  = 1'b1;
      end else if (a_cls.inf) begin
        spec_hit  = 1'b1;
        spec_kind = KIND_INF;
      end
    end
  end

  // Next-state and handshake/datapath control outputs
  always_comb begin
    state_d        = state_q;
    o_ready        = 1'b0;
    o_dp_start     = 1'b0;
    o_dp_step      = 1'b0;
    o_result_valid = 1'b0;
    case (state_q)
      IDLE: begin
        o_ready = 1'b1;
        if (i_valid) state_d = CHECK;
      end
      CHECK: begin
        o_dp_start = !spec_hit;
        state_d    = spec_hit ? DONE : ITER;
      end
      ITER: begin
        o_dp_step = 1'b1;
        if (cnt_q == LAST) state_d = DONE;
      end
      DONE: begin
        o_result_valid = 1'b1;
        if (i_result_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (i_kill) state_d = IDLE;
  end

  // State register
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Operand capture in IDLE
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      op_q     <= 1'b0;
      a_sign_q <= 1'b0;
      a_exp_q  <= '0;
      a_frac_q <= '0;
      b_sign_q <= 1'b0;
      b_exp_q  <= '0;
      b_frac_q <= '0;
    end else if (state_q == IDLE && i_valid && !i_kill) begin
      op_q     <= i_op;
      a_sign_q <= i_a_sign;
      a_exp_q  <= i_a_exp;
      a_frac_q <= i_a_frac;
      b_sign_q <= i_b_sign;
      b_exp_q  <= i_b_exp;
      b_frac_q <= i_b_frac;
    end
  end

  // Step counter, subnormal markers and result latches; all cleared on kill
  // and on handoff so they read zero outside their owning states
  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_kill) begin
      cnt_q         <= '0;
      a_sub_q       <= 1'b0;
      b_sub_q       <= 1'b0;
      res_special_q <= 1'b0;
      res_kind_q    <= KIND_QNAN;
      res_sign_q    <= 1'b0;
      res_nv_q      <= 1'b0;
      res_dz_q      <= 1'b0;
    end else begin
      case (state_q)
        CHECK: begin
          cnt_q         <= '0;
          a_sub_q       <= !spec_hit && a_cls.sub;
          b_sub_q       <= !spec_hit && !op_q && b_cls.sub;
          res_special_q <= spec_hit;
          res_kind_q    <= spec_kind;
          res_sign_q    <= spec_sign;
          res_nv_q      <= spec_nv;
          res_dz_q      <= spec_dz;
        end
        ITER: cnt_q <= (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        DONE: if (i_result_ready) begin
          a_sub_q       <= 1'b0;
          b_sub_q       <= 1'b0;
          res_special_q <= 1'b0;
          res_kind_q    <= KIND_QNAN;
          res_sign_q    <= 1'b0;
          res_nv_q      <= 1'b0;
          res_dz_q      <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign o_iter_cnt     = cnt_q;
  assign o_a_subnormal  = a_sub_q;
  assign o_b_subnormal  = b_sub_q;
  assign o_special      = res_special_q;
  assign o_special_kind = res_kind_q;
  assign o_special_sign = res_sign_q;
  assign o_flag_nv      = res_nv_q;
  assign o_flag_dz      = res_dz_q;

endmodule

// File: tb/tb_fp_divsqrt_seq.sv
// Self-checking bench for fp_divsqrt_seq: directed scenarios plus random
// operand classes checked against an IEEE-rule reference model.
module tb_fp_divsqrt_seq;

  localparam int ITERS = 27;
  localparam int CW    = $clog2(ITERS + 1);

  logic          i_clk;
  logic          i_rst_n;
  logic          i_valid;
  logic          o_ready;
  logic          i_op;
  logic          i_a_sign;
  logic [7:0]    i_a_exp;
  logic [22:0]   i_a_frac;
  logic          i_b_sign;
  logic [7:0]    i_b_exp;
  logic [22:0]   i_b_frac;
  logic          i_kill;
  logic          o_dp_start;
  logic          o_dp_step;
  logic [CW-1:0] o_iter_cnt;
  logic          o_a_subnormal;
  logic          o_b_subnormal;
  logic          o_result_valid;
  logic          i_result_ready;
  logic          o_special;
  logic [1:0]    o_special_kind;
  logic          o_special_sign;
  logic          o_flag_nv;
  logic          o_flag_dz;

  fp_divsqrt_seq #(.EXP_BITS(8), .FRAC_BITS(23), .ITERS(ITERS)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(o_ready),
    .i_op(i_op), .i_a_sign(i_a_sign), .i_a_exp(i_a_exp), .i_a_frac(i_a_frac),
    .i_b_sign(i_b_sign), .i_b_exp(i_b_exp), .i_b_frac(i_b_frac), .i_kill(i_kill),
    .o_dp_start(o_dp_start), .o_dp_step(o_dp_step), .o_iter_cnt(o_iter_cnt),
    .o_a_subnormal(o_a_subnormal), .o_b_subnormal(o_b_subnormal),
    .o_result_valid(o_result_valid), .i_result_ready(i_result_ready),
    .o_special(o_special), .o_special_kind(o_special_kind),
    .o_special_sign(o_special_sign), .o_flag_nv(o_flag_nv), .o_flag_dz(o_flag_dz)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit       special;
    bit [1:0] kind;
    bit       sign;
    bit       nv;
    bit       dz;
    bit       asub;
    bit       bsub;
  } ref_t;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  function automatic logic [31:0] all_outs();
    return 32'({o_ready, o_dp_start, o_dp_step, o_iter_cnt, o_a_subnormal, o_b_subnormal,
                o_result_valid, o_special, o_special_kind, o_special_sign, o_flag_nv, o_flag_dz});
  endfunction

  // Reset-value image: only o_ready set (bit 16 of the 17-bit packing)
  localparam logic [31:0] RESET_OUTS = 32'h0001_0000;

  // Reference model from IEEE-754 single-precision rules on raw bit patterns
  function automatic ref_t model(input bit op, input bit [31:0] a, input bit [31:0] b);
    ref_t r;
    bit [30:0] ma = a[30:0];
    bit [30:0] mb = b[30:0];
    bit a_nan  = ma > 31'h7F80_0000;
    bit b_nan  = mb > 31'h7F80_0000;
    bit a_snan = a_nan && (a[22] == 1'b0);
    bit b_snan = b_nan && (b[22] == 1'b0);
    bit a_inf  = ma == 31'h7F80_0000;
    bit b_inf  = mb == 31'h7F80_0000;
    bit a_zero = ma == 31'd0;
    bit b_zero = mb == 31'd0;
    bit a_sub  = !a_zero && ma < 31'h0080_0000;
    bit b_sub  = !b_zero && mb < 31'h0080_0000;
    bit sx     = a[31] ^ b[31];
    r = '{default: 0};
    if (op == 1'b0) begin
      if (a_nan || b_nan)                          begin r.special = 1; r.kind = 0; r.nv = a_snan || b_snan; end
      else if ((a_inf && b_inf) || (a_zero && b_zero)) begin r.special = 1; r.kind = 0; r.nv = 1; end
      else if (a_inf)                              begin r.special = 1; r.kind = 1; r.sign = sx; end
      else if (b_zero)                             begin r.special = 1; r.kind = 1; r.sign = sx; r.dz = 1; end
      else if (a_zero || b_inf)                    begin r.special = 1; r.kind = 2; r.sign = sx; end
      else                                         begin r.asub = a_sub; r.bsub = b_sub; end
    end else begin
      if (a_nan)        begin r.special = 1; r.kind = 0; r.nv = a_snan; end
      else if (a_zero)  begin r.special = 1; r.kind = 2; r.sign = a[31]; end
      else if (a[31])   begin r.special = 1; r.kind = 0; r.nv = 1; end
      else if (a_inf)   begin r.special = 1; r.kind = 1; end
      else              begin r.asub = a_sub; end
    end
    return r;
  endfunction

  function automatic bit [31:0] rnd_fp();
    bit        s = 1'($urandom);
    bit [22:0] f = 23'($urandom);
    case ($urandom_range(0, 6))
      0: return {s, 8'h00, 23'h0};
      1: return {s, 8'hFF, 23'h0};
      2: return {s, 8'hFF, 1'b1, f[21:0]};
      3: return {s, 8'hFF, 1'b0, 22'($urandom_range(1, 32'h3F_FFFF))};
      4: return {s, 8'h00, 23'($urandom_range(1, 32'h7F_FFFF))};
      default: return {s, 8'($urandom_range(1, 254)), f};
    endcase
  endfunction

  task automatic drive_req(input bit op, input bit [31:0] a, input bit [31:0] b);
    i_valid  = 1'b1;
    i_op     = op;
    i_a_sign = a[31]; i_a_exp = a[30:23]; i_a_frac = a[22:0];
    i_b_sign = b[31]; i_b_exp = b[30:23]; i_b_frac = b[22:0];
  endtask

  task automatic scramble_inputs();
    i_valid  = 1'b0;
    i_op     = 1'($urandom);
    i_a_sign = 1'($urandom); i_a_exp = 8'($urandom); i_a_frac = 23'($urandom);
    i_b_sign = 1'($urandom); i_b_exp = 8'($urandom); i_b_frac = 23'($urandom);
  endtask

  // One complete request: accept, observe datapath control, check result, handoff
  task automatic run_op(input string nm, input bit op, input bit [31:0] a,
                        input bit [31:0] b, input int hold);
    ref_t r = model(op, a, b);
    int starts = 0, steps = 0, seq_err = 0, sub_err = 0, lat = -1, cyc = 1;
    logic [31:0] snap;
    chk({nm, " ready_idle"}, 32'(o_ready), 32'd1);
    drive_req(op, a, b);
    tick();
    scramble_inputs();
    while (lat < 0 && cyc <= ITERS + 10) begin
      if (o_result_valid) lat = cyc;
      else begin
        if (o_dp_start) begin starts++; if (cyc != 1) seq_err++; end
        if (o_dp_start && o_dp_step) seq_err++;
        if (o_dp_step) begin
          if (o_iter_cnt !== CW'(steps)) seq_err++;
          if (cyc != steps + 2) seq_err++;
          if (o_a_subnormal !== r.asub || o_b_subnormal !== r.bsub) sub_err++;
          steps++;
        end
        if (o_ready) seq_err++;
        tick();
        cyc++;
      end
    end
    chk({nm, " latency"}, 32'(lat), r.special ? 32'd2 : 32'(ITERS + 2));
    chk({nm, " starts"}, 32'(starts), r.special ? 32'd0 : 32'd1);
    chk({nm, " steps"}, 32'(steps), r.special ? 32'd0 : 32'(ITERS));
    chk({nm, " sequence"}, 32'(seq_err), 32'd0);
    chk({nm, " subnormal"}, 32'(sub_err), 32'd0);
    snap = 32'({o_ready, o_result_valid, o_special, o_special_kind, o_special_sign, o_flag_nv, o_flag_dz});
    chk({nm, " result"}, snap, 32'({1'b0, 1'b1, r.special, r.kind, r.sign, r.nv, r.dz}));
    for (int h = 0; h < hold; h++) begin
      tick();
      chk({nm, " hold"}, 32'({o_ready, o_result_valid, o_special, o_special_kind,
                              o_special_sign, o_flag_nv, o_flag_dz}), snap);
    end
    i_result_ready = 1'b1;
    tick();
    i_result_ready = 1'b0;
    chk({nm, " handoff"}, 32'({o_ready, o_result_valid}), 32'b10);
  endtask

  task automatic wait_step10(input string nm);
    int w = 0;
    while (!(o_dp_step && o_iter_cnt == CW'(10)) && w < 40) begin tick(); w++; end
    chk({nm, " reach_step10"}, 32'(w < 40), 32'd1);
  endtask

  task automatic watch_no_result(input string nm);
    int seen = 0;
    for (int c = 0; c < ITERS + 10; c++) begin
      if (o_result_valid || o_dp_step || !o_ready) seen++;
      tick();
    end
    chk({nm, " quiet"}, 32'(seen), 32'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    i_rst_n = 1'b0; i_kill = 1'b0; i_result_ready = 1'b0;
    scramble_inputs();
    tick(); tick();
    chk("reset_outs", all_outs(), RESET_OUTS);
    i_rst_n = 1'b1;
    tick();
    chk("idle_outs", all_outs(), RESET_OUTS);

    run_op("div_3_1",      1'b0, 32'h4040_0000, 32'h3F80_0000, 0);
    run_op("div_1_m0",     1'b0, 32'h3F80_0000, 32'h8000_0000, 0);
    run_op("div_snan_q",   1'b0, 32'h7F80_0001, 32'h7FC0_0000, 1);
    run_op("div_qnan_1",   1'b0, 32'h7FC0_0000, 32'h3F80_0000, 0);
    run_op("div_inf_minf", 1'b0, 32'h7F80_0000, 32'hFF80_0000, 0);
    run_op("div_0_0",      1'b0, 32'h0000_0000, 32'h8000_0000, 0);
    run_op("div_0_sub",    1'b0, 32'h8000_0000, 32'h0000_0005, 0);
    run_op("div_sub_sub",  1'b0, 32'h0000_0003, 32'h8000_0001, 0);
    run_op("sqrt_m1",      1'b1, 32'hBF80_0000, 32'h0, 0);
    run_op("sqrt_m0",      1'b1, 32'h8000_0000, 32'h0, 0);
    run_op("sqrt_sub",     1'b1, 32'h0000_0001, 32'h0, 0);
    run_op("sqrt_pinf",    1'b1, 32'h7F80_0000, 32'hFFFF_FFFF, 0);
    run_op("div_hold5",    1'b0, 32'h40A0_0000, 32'h4000_0000, 5);

    // Kill with a request pending in IDLE must not accept it
    drive_req(1'b0, 32'h4040_0000, 32'h3F80_0000);
    i_kill = 1'b1;
    tick();
    i_kill = 1'b0;
    scramble_inputs();
    chk("kill_idle_outs", all_outs(), RESET_OUTS);

    // Kill mid-ITER
    drive_req(1'b0, 32'h4040_0000, 32'h3F80_0000);
    tick();
    scramble_inputs();
    wait_step10("kill");
    i_kill = 1'b1;
    tick();
    i_kill = 1'b0;
    chk("kill_after", 32'({o_ready, o_dp_step, o_result_valid}), 32'b100);
    watch_no_result("kill");
    run_op("after_kill", 1'b0, 32'h4040_0000, 32'h3F80_0000, 0);

    // Reset mid-ITER
    drive_req(1'b1, 32'h4080_0000, 32'h0);
    tick();
    scramble_inputs();
    wait_step10("rst");
    i_rst_n = 1'b0;
    tick();
    chk("rst_mid_outs", all_outs(), RESET_OUTS);
    i_rst_n = 1'b1;
    watch_no_result("rst");
    run_op("after_rst", 1'b1, 32'h4080_0000, 32'h0, 0);

    for (int n = 0; n < 40; n++) begin
      bit [31:0] ra = rnd_fp();
      bit [31:0] rb = rnd_fp();
      run_op($sformatf("rnd%0d", n), 1'($urandom), ra, rb, int'($urandom_range(0, 3)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
